// File: rtl/psum_ofifo_if.sv
// Bus bundle for psum_ofifo: per-column write side, row read side and status flags.
interface psum_ofifo_if #(
    parameter int unsigned COL     = 8,
    parameter int unsigned PSUM_BW = 16,
    parameter int unsigned DEPTH   = 16
);
    logic [COL-1:0]           wr;
    logic [PSUM_BW*COL-1:0]   in;
    logic                     rd;
    logic [PSUM_BW*COL-1:0]   out;
    logic                     o_out_valid;
    logic                     o_valid;
    logic                     o_ready;
    logic                     o_full;
    logic                     o_empty;
    logic [$clog2(DEPTH):0]   o_rows;
    logic [COL-1:0]           o_ovf;
    logic [7:0]               o_drop_cnt;

    modport master (
        output wr, in, rd,
        input  out, o_out_valid, o_valid, o_ready, o_full, o_empty, o_rows, o_ovf, o_drop_cnt
    );

    modport slave (
        input  wr, in, rd,
        output out, o_out_valid, o_valid, o_ready, o_full, o_empty, o_rows, o_ovf, o_drop_cnt
    );
endinterface

// File: rtl/psum_ofifo.sv
// Partial-sum output FIFO: COL independent column buffers drained together as rows.
// Optional overflow status (sticky flags + drop counter) enabled by PSUM_OFIFO_OVF_STATUS_EN.
module psum_ofifo #(
    parameter int unsigned COL     = 8,
    parameter int unsigned PSUM_BW = 16,
    parameter int unsigned DEPTH   = 16
) (
    input  logic               clk,
    input  logic               reset,
    psum_ofifo_if.slave        bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]        r_rptr;
    logic [PSUM_BW*COL-1:0] r_out;
    logic                 r_out_valid;

    logic [CW-1:0]        w_cnt  [COL];
    logic [PSUM_BW-1:0]   w_head [COL];
    logic [COL-1:0]       w_full;
    logic [COL-1:0]       w_nonempty;
    logic [COL-1:0]       w_wr_acc;
    logic                 w_valid;
    logic                 w_pop;
    logic [CW-1:0]        w_rows;

    assign w_valid = &w_nonempty;
    assign w_pop   = bus.rd & w_valid;

    // Per-column storage: own write pointer and occupancy, shared read pointer.
    for (genvar g = 0; g < COL; g++) begin : g_col
        logic [AW-1:0]      r_wptr;
        logic [CW-1:0]      r_cnt;
        logic [PSUM_BW-1:0] r_mem [DEPTH];

        assign w_full[g]     = (r_cnt == CW'(DEPTH));
        assign w_nonempty[g] = (r_cnt != '0);
        // A full column still accepts when a row is leaving on the same edge.
        assign w_wr_acc[g]   = bus.wr[g] & (~w_full[g] | w_pop);
        assign w_cnt[g]      = r_cnt;
        assign w_head[g]     = r_mem[r_rptr];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_wr_acc[g]) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                case ({w_wr_acc[g], w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!reset && w_wr_acc[g]) begin
                r_mem[r_wptr] <= bus.in[PSUM_BW*g +: PSUM_BW];
            end
        end
    end

    // Row read side: shared pointer and registered output row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_pop;
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                for (int i = 0; i < COL; i++) begin
                    r_out[PSUM_BW*i +: PSUM_BW] <= w_head[i];
                end
            end
        end
    end

    // Complete rows available is the shallowest column.
    always_comb begin
        w_rows = w_cnt[0];
        for (int i = 1; i < COL; i++) begin
            if (w_cnt[i] < w_rows) begin
                w_rows = w_cnt[i];
            end
        end
    end

    assign bus.out         = r_out;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_valid     = w_valid;
    assign bus.o_full      = |w_full;
    assign bus.o_ready     = ~(|w_full);
    assign bus.o_empty     = ~(|w_nonempty);
    assign bus.o_rows      = w_rows;

`ifdef PSUM_OFIFO_OVF_STATUS_EN
    localparam int unsigned NW = $clog2(COL + 1);

    logic [COL-1:0] r_ovf;
    logic [7:0]     r_drop_cnt;
    logic [COL-1:0] w_drop;
    logic [NW-1:0]  w_ndrop;
    logic [8:0]     w_sum;

    assign w_drop = bus.wr & ~w_wr_acc;

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < COL; i++) begin
            w_ndrop = w_ndrop + NW'(w_drop[i]);
        end
    end

    assign w_sum = 9'(r_drop_cnt) + 9'(w_ndrop);

    // Sticky per-column flags and a saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_ovf      <= r_ovf | w_drop;
            r_drop_cnt <= (w_sum > 9'd255) ? 8'hFF : w_sum[7:0];
        end
    end

    assign bus.o_ovf      = r_ovf;
    assign bus.o_drop_cnt = r_drop_cnt;
`else
    assign bus.o_ovf      = '0;
    assign bus.o_drop_cnt = '0;
`endif

endmodule
